ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the RI5CY instruction and data
//  ports. Each side uses the core's req/gnt/rvalid protocol. Default policy is data
//  priority with an instruction-starvation guard. Sits between the core and a
//  1-cycle-latency single-port RAM.
// PARAMETERS
//  ADDR_WIDTH  16  byte-address width of both requesters and the RAM port
//  MAX_WAIT    4   consecutive blocked cycles before instr is forced priority (>=1)
// PORTS
//  clk             in   1           clock, all state on posedge
//  rst             in   1           synchronous reset, active-high
//  instr_req_i     in   1           instruction request
//  instr_addr_i    in   ADDR_WIDTH  instruction address
//  instr_gnt_o     out  1           instr request accepted this cycle
//  instr_rvalid_o  out  1           instr read data valid
//  instr_rdata_o   out  32          instr read data
//  data_req_i      in   1           data request
//  data_addr_i     in   ADDR_WIDTH  data address
//  data_we_i       in   1           1 = write
//  data_be_i       in   4           byte enables
//  data_wdata_i    in   32          write data
//  data_gnt_o      out  1           data request accepted this cycle
//  data_rvalid_o   out  1           data response valid (reads and writes)
//  data_rdata_o    out  32          data read data
//  mem_en_o        out  1           RAM access strobe
//  mem_addr_o      out  ADDR_WIDTH  RAM address
//  mem_we_o        out  1           RAM write enable
//  mem_be_o        out  4           RAM byte enables
//  mem_wdata_o     out  32          RAM write data
//  mem_rdata_i     in   32          RAM read data, valid 1 cycle after mem_en_o
// BEHAVIOUR
//  - Grant is combinational, same cycle as req; at most one gnt per cycle.
//    mem_en_o = instr_gnt_o | data_gnt_o; mem_* muxed from the granted side.
//    Instr grant drives mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
//  - Policy: both req -> data wins, unless wait_cnt == MAX_WAIT -> instr wins.
//    A single req is always granted.
//  - wait_cnt (width $clog2(MAX_WAIT+1)): +1 per cycle instr_req_i & !instr_gnt_o,
//    saturates at MAX_WAIT; cleared to 0 on instr_gnt_o or !instr_req_i.
//  - Response FSM on owner register: IDLE / RSP_I / RSP_D. Next state is the side
//    granted this cycle, else IDLE. Back-to-back grants are legal (full throughput).
//    RSP_I: instr_rvalid_o=1, instr_rdata_o=mem_rdata_i. RSP_D: data_rvalid_o=1,
//    data_rdata_o=mem_rdata_i. Latency gnt->rvalid = exactly 1 cycle.
//  - rdata outputs are 0 when the matching rvalid is 0 (no X propagation).
//  - Reset: owner=IDLE, wait_cnt=0, last_grant=data. All rvalid outputs are 0 in
//    the cycle after reset is asserted. Gnt outputs are 0 while rst=1. A grant in
//    the cycle rst rises is discarded: no rvalid follows.
//  - Requesters hold req/addr until gnt; the arbiter does not latch ungranted requests.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: strict alternation on conflict using last_grant
//  (1-bit reg, updated on every grant). wait_cnt and MAX_WAIT are unused; the guard
//  logic is not built.
//  Not defined: data priority plus starvation guard as above.
// TESTING
//  1 instr_req only, addr 0x0100, RAM word 0xDEADBEEF -> instr_gnt same cycle;
//    instr_rvalid next cycle with 0xDEADBEEF.
//  2 data write 0x0040 be=4'b0011 wdata=0x12345678, then read 0x0040 (prior word 0)
//    -> rvalid on both; read returns 0x00005678.
//  3 both req held 10 cycles, MAX_WAIT=4 -> data granted cycles 0-3, instr cycle 4,
//    data 5-8, instr 9 (guard mode); RR mode: grants alternate I/D from data first.
//  4 alternating I/D grants each cycle -> each rvalid goes to the correct port
//    with the correct word; no lost or duplicated responses.
//  5 rst asserted in the cycle after a data read gnt -> data_rvalid_o=0 that cycle;
//    wait_cnt=0, owner=IDLE after reset.
//  6 no reqs -> mem_en_o=0, both rvalid=0, both rdata=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between the RI5CY instr and data ports.
// Default: data priority with instr starvation guard; define RAM_ARB_ROUND_ROBIN_EN for alternation.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,
   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);

   // Handshake: a side's req is accepted in the cycle its gnt is high; exactly one
   // cycle later its rvalid is high for one cycle carrying the RAM word.
   typedef enum logic [1:0] {IDLE, RSP_I, RSP_D} owner_t;

   owner_t owner_q, owner_d;
   logic   instr_wins;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_grant_q;  // 1 = data was granted most recently

   always_comb begin
      instr_wins = instr_req_i & (~data_req_i | last_grant_q);
   end

   always_ff @(posedge clk) begin
      if (rst)              last_grant_q <= 1'b1;
      else if (instr_gnt_o) last_grant_q <= 1'b0;
      else if (data_gnt_o)  last_grant_q <= 1'b1;
   end
`else
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

   logic [CW-1:0] wait_cnt_q;

   always_comb begin
      instr_wins = instr_req_i & (~data_req_i | (wait_cnt_q == WAIT_LIMIT));
   end

   // Counts consecutive blocked instr cycles; saturates so the guard stays armed.
   always_ff @(posedge clk) begin
      if (rst || !instr_req_i || instr_gnt_o) wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_LIMIT)      wait_cnt_q <= wait_cnt_q + 1'b1;
   end
`endif

   assign instr_gnt_o = ~rst & instr_wins;
   assign data_gnt_o  = ~rst & data_req_i & ~instr_wins;

   assign mem_en_o    = instr_gnt_o | data_gnt_o;
   assign mem_addr_o  = instr_gnt_o ? instr_addr_i : data_addr_i;
   assign mem_we_o    = data_gnt_o & data_we_i;
   assign mem_be_o    = instr_gnt_o ? 4'hF : (data_gnt_o ? data_be_i : 4'h0);
   assign mem_wdata_o = data_gnt_o ? data_wdata_i : 32'h0;

   always_comb begin
      owner_d = IDLE;
      if (instr_gnt_o)     owner_d = RSP_I;
      else if (data_gnt_o) owner_d = RSP_D;
   end

   always_ff @(posedge clk) begin
      if (rst) owner_q <= IDLE;
      else     owner_q <= owner_d;
   end

   // Gating with rst drops a response whose grant preceded a reset.
   assign instr_rvalid_o = ~rst & (owner_q == RSP_I);
   assign data_rvalid_o  = ~rst & (owner_q == RSP_D);
   assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
   assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: drivers push expected responses, a monitor pops them.
module tb_ram_port_arbiter;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_req_i, instr_gnt_o, instr_rvalid_o;
   logic [AW-1:0] instr_addr_i;
   logic [31:0]   instr_rdata_o;
   logic          data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
   logic [AW-1:0] data_addr_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_wdata_i, data_rdata_o;
   logic          mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [3:0]    mem_be_o;
   logic [31:0]   mem_wdata_o, mem_rdata_i;

   logic [31:0] exp_iq[$];
   logic [31:0] exp_dq[$];
   int checks = 0;
   int failures = 0;

   // clock / reset
   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // 1-cycle-latency RAM model; write cycles return 0
   logic        ram_load;
   logic [31:0] ram [0:255];
   logic [31:0] ram_q;

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
         ram[8'h40] <= 32'hDEADBEEF;
         ram[8'h41] <= 32'h11111111;
         ram[8'h42] <= 32'h22222222;
         ram[8'h20] <= 32'hA5A5A5A5;
         ram[8'h21] <= 32'h5A5A5A5A;
         ram_q      <= 32'h0;
      end else if (mem_en_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            ram_q <= 32'h0;
         end else begin
            ram_q <= ram[mem_addr_o[9:2]];
         end
      end
   end
   assign mem_rdata_i = ram_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (instr_rvalid_o) begin
         if (exp_iq.size() == 0) check("instr_rvalid_unexpected", 32'(instr_rvalid_o), 32'h0);
         else                    check("instr_rdata", instr_rdata_o, exp_iq.pop_front());
      end else begin
         check("instr_rdata_idle", instr_rdata_o, 32'h0);
      end
      if (data_rvalid_o) begin
         if (exp_dq.size() == 0) check("data_rvalid_unexpected", 32'(data_rvalid_o), 32'h0);
         else                    check("data_rdata", data_rdata_o, exp_dq.pop_front());
      end else begin
         check("data_rdata_idle", data_rdata_o, 32'h0);
      end
   end

   logic [AW-1:0] t4_addr [4];
   logic [31:0]   t4_word [4];

   initial begin
      t4_addr = '{16'h0104, 16'h0080, 16'h0108, 16'h0084};
      t4_word = '{32'h11111111, 32'hA5A5A5A5, 32'h22222222, 32'h5A5A5A5A};
      rst = 1'b1; ram_load = 1'b1;
      instr_req_i = 1'b0; instr_addr_i = '0;
      data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = '0;
      repeat (3) step();
      ram_load = 1'b0;

      // requests during reset are not granted
      instr_req_i = 1'b1; data_req_i = 1'b1;
      @(negedge clk);
      check("rst_instr_gnt", 32'(instr_gnt_o), 32'h0);
      check("rst_data_gnt", 32'(data_gnt_o), 32'h0);
      step();
      rst = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0;

      // idle: no RAM access, no responses
      @(negedge clk);
      check("idle_mem_en", 32'(mem_en_o), 32'h0);
      check("idle_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
      check("idle_data_rvalid", 32'(data_rvalid_o), 32'h0);
      step();

      // single instr fetch
      instr_req_i = 1'b1; instr_addr_i = 16'h0100;
      @(negedge clk);
      check("t1_instr_gnt", 32'(instr_gnt_o), 32'h1);
      check("t1_data_gnt", 32'(data_gnt_o), 32'h0);
      check("t1_mem_en", 32'(mem_en_o), 32'h1);
      check("t1_mem_addr", 32'(mem_addr_o), 32'h0100);
      check("t1_mem_we", 32'(mem_we_o), 32'h0);
      check("t1_mem_be", 32'(mem_be_o), 32'hF);
      check("t1_mem_wdata", mem_wdata_o, 32'h0);
      exp_iq.push_back(32'hDEADBEEF);
      step();
      instr_req_i = 1'b0;

      // partial write then read back
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 16'h0040;
      data_be_i = 4'b0011; data_wdata_i = 32'h12345678;
      @(negedge clk);
      check("t2_wr_gnt", 32'(data_gnt_o), 32'h1);
      check("t2_mem_we", 32'(mem_we_o), 32'h1);
      check("t2_mem_be", 32'(mem_be_o), 32'h3);
      check("t2_mem_wdata", mem_wdata_o, 32'h12345678);
      exp_dq.push_back(32'h0);
      step();
      data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = '0;
      @(negedge clk);
      check("t2_rd_gnt", 32'(data_gnt_o), 32'h1);
      exp_dq.push_back(32'h00005678);
      step();
      data_req_i = 1'b0;

      // contention with starvation guard: D D D D I D D D D I
      instr_req_i = 1'b1; instr_addr_i = 16'h0100;
      data_req_i = 1'b1; data_addr_i = 16'h0040;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("t3_instr_gnt_c%0d", c), 32'(instr_gnt_o), 32'((c == 4) || (c == 9)));
         check($sformatf("t3_data_gnt_c%0d", c), 32'(data_gnt_o), 32'(!((c == 4) || (c == 9))));
         if ((c == 4) || (c == 9)) exp_iq.push_back(32'hDEADBEEF);
         else                      exp_dq.push_back(32'h00005678);
         step();
      end
      instr_req_i = 1'b0; data_req_i = 1'b0;

      // alternating single-side grants, back to back
      for (int k = 0; k < 4; k++) begin
         instr_req_i = (k % 2 == 0); data_req_i = (k % 2 == 1);
         instr_addr_i = t4_addr[k]; data_addr_i = t4_addr[k];
         @(negedge clk);
         if (k % 2 == 0) begin
            check($sformatf("t4_instr_gnt_%0d", k), 32'(instr_gnt_o), 32'h1);
            exp_iq.push_back(t4_word[k]);
         end else begin
            check($sformatf("t4_data_gnt_%0d", k), 32'(data_gnt_o), 32'h1);
            exp_dq.push_back(t4_word[k]);
         end
         step();
      end
      instr_req_i = 1'b0; data_req_i = 1'b0;
      step();

      // reset right after a data read grant drops its response and clears the guard
      instr_req_i = 1'b1; instr_addr_i = 16'h0100;
      data_req_i = 1'b1; data_addr_i = 16'h0080;
      @(negedge clk);
      check("t5_pre_gnt0", 32'(data_gnt_o), 32'h1);
      exp_dq.push_back(32'hA5A5A5A5);
      step();
      @(negedge clk);
      check("t5_pre_gnt1", 32'(data_gnt_o), 32'h1);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_data_rvalid", 32'(data_rvalid_o), 32'h0);
      check("t5_rst_data_gnt", 32'(data_gnt_o), 32'h0);
      step();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("t5_post_instr_gnt_c%0d", c), 32'(instr_gnt_o), 32'(c == 4));
         if (c == 4) exp_iq.push_back(32'hDEADBEEF);
         else        exp_dq.push_back(32'hA5A5A5A5);
         step();
      end
      instr_req_i = 1'b0; data_req_i = 1'b0;
      repeat (3) step();

      check("final_instr_q_empty", 32'(exp_iq.size()), 32'h0);
      check("final_data_q_empty", 32'(exp_dq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
